// File: rtl/mux_pkg.sv
// Shared types and limits for the registered N-input selector stage.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_t;

  localparam int MAX_N_IN = 16;

endpackage

// File: rtl/mux_n.sv
// Combinational WIDTH x N_IN word selector; out-of-range selects yield zero.
module mux_n #(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_word,
  output logic                  out_of_range
);

  logic [31:0] w_sel_ext;

  assign w_sel_ext    = 32'(sel);
  assign out_of_range = (w_sel_ext >= 32'(N_IN));

  always_comb begin
    out_word = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (w_sel_ext == k) out_word = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_stage.sv
// Registered N-input selector with valid/ready handshake, two-entry skid
// buffer, flush, and a sticky flag for out-of-range selects.
module mux_n_stage
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  if (N_IN < 2 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("mux_n_stage: N_IN must be within 2..MAX_N_IN");
  end

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_oor;
  logic             w_accept;
  logic             w_pop;
  logic             r_sel_err;

  mux_n #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux_n (
    .in_data      (in_data),
    .sel          (sel),
    .out_word     (w_word),
    .out_of_range (w_oor)
  );

  assign in_ready  = reset_n & (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_main_nxt  = w_word;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_main_nxt = w_word;
        end else if (w_accept) begin
          w_state_nxt = TWO;
          w_skid_nxt  = w_word;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_state_nxt = ONE;
          w_main_nxt  = r_skid;
          w_skid_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_main_nxt  = '0;
        w_skid_nxt  = '0;
      end
    endcase
    // Flush overrides everything: any same-cycle accept is dropped.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      if (w_accept && w_oor) r_sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_n_stage.sv
// Scoreboard bench for mux_n_stage: a 64-bit 4-input instance under directed
// and random traffic, plus an 8-bit 5-input instance for bad-select handling.
module tb_mux_n_stage;

  logic         clk;
  int           total;
  int           bad;

  // Instance A: WIDTH=64, N_IN=4
  logic         reset_n;
  logic [255:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;

  // Instance B: WIDTH=8, N_IN=5
  logic         b_reset_n;
  logic [39:0]  b_in_data;
  logic [2:0]   b_sel;
  logic         b_in_valid;
  logic         b_in_ready;
  logic         b_flush;
  logic [7:0]   b_out_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic         b_sel_err;

  logic [63:0]  q[$];

  mux_n_stage #(.WIDTH(64), .N_IN(4)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  mux_n_stage #(.WIDTH(8), .N_IN(5)) dut_b (
    .clk       (clk),
    .reset_n   (b_reset_n),
    .in_data   (b_in_data),
    .sel       (b_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .flush     (b_flush),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .sel_err   (b_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // One cycle of instance A: check outputs against the model, then advance it.
  task automatic tick();
    logic [63:0] exp_d;
    logic [63:0] w;
    bit          acc;
    bit          pop;
    #1;
    exp_d = (q.size() != 0) ? q[0] : 64'h0;
    chk("in_ready",  64'(in_ready),  64'(reset_n && q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_data",  out_data,       exp_d);
    chk("sel_err",   64'(sel_err),   64'h0);
    acc = reset_n && in_valid && (q.size() < 2);
    pop = reset_n && (q.size() != 0) && out_ready;
    w   = in_data[sel*64 +: 64];
    @(posedge clk);
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic b_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    in_data    = {64'h4444444444444444, 64'h3333333333333333,
                  64'h2222222222222222, 64'h1111111111111111};
    sel        = '0;
    in_valid   = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    b_reset_n  = 1'b0;
    b_in_data  = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    b_sel      = '0;
    b_in_valid = 1'b0;
    b_flush    = 1'b0;
    b_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Instance B: reset state, bad select, sticky flag, clear on reset
    #1;
    chk("b_rst_in_ready",  64'(b_in_ready),  64'h0);
    chk("b_rst_out_valid", 64'(b_out_valid), 64'h0);
    chk("b_rst_out_data",  64'(b_out_data),  64'h0);
    chk("b_rst_sel_err",   64'(b_sel_err),   64'h0);
    b_reset_n  = 1'b1;
    b_in_valid = 1'b1;
    b_sel      = 3'd6;
    #1;
    chk("b_rel_in_ready", 64'(b_in_ready), 64'h1);
    b_cycle();
    b_in_valid = 1'b0;
    #1;
    chk("b_bad_out_valid", 64'(b_out_valid), 64'h1);
    chk("b_bad_out_data",  64'(b_out_data),  64'h0);
    chk("b_bad_sel_err",   64'(b_sel_err),   64'h1);
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_sel       = 3'd4;
    b_cycle();
    b_in_valid = 1'b0;
    #1;
    chk("b_last_out_data", 64'(b_out_data), 64'h55);
    chk("b_last_valid",    64'(b_out_valid), 64'h1);
    chk("b_sticky",        64'(b_sel_err),  64'h1);
    b_cycle();
    #1;
    chk("b_drain_valid", 64'(b_out_valid), 64'h0);
    chk("b_drain_data",  64'(b_out_data),  64'h0);
    b_sel     = 3'd7;
    b_reset_n = 1'b0;
    b_cycle();
    b_reset_n = 1'b1;
    #1;
    chk("b_clr_sel_err", 64'(b_sel_err), 64'h0);
    b_cycle();
    #1;
    chk("b_idle_bad_sel", 64'(b_sel_err),  64'h0);
    chk("b_idle_valid",   64'(b_out_valid), 64'h0);

    // Instance A: reset state
    tick();

    // Latency and streaming at full rate
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 2'd2;
    tick();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Backpressure: third word must be refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Flush while full, with a word offered at the same time
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    sel   = 2'd3;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset while holding one entry
    in_valid = 1'b1;
    sel      = 2'd1;
    tick();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Random traffic
    repeat (10000) begin
      for (int k = 0; k < 4; k++) in_data[k*64 +: 64] = {$urandom, $urandom};
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_stage.md
# mux_n_stage

Parametrised W-bit, N-input selector with a registered output stage and a valid/ready handshake. It sits between pipeline stages of the CPU, for example as the operand-forwarding select feeding the EX register. A two-entry skid buffer keeps full throughput under backpressure while `in_ready` stays a registered-state function. Flush support lets the hazard unit squash in-flight selections.

## Interface
Parameters:
- `WIDTH`, 64: data width per input.
- `N_IN`, 4: number of inputs, 2..16; need not be a power of two.
- `SEL_W`, `$clog2(N_IN)`: select width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_data`  in  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- `sel`  in  SEL_W  input index, sampled with `in_data` on accept.
- `in_valid`  in  1  upstream offers `in_data`/`sel`.
- `in_ready`  out  1  block can accept this cycle.
- `flush`  in  1  discard all held entries.
- `out_data`  out  WIDTH  selected word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `sel_err`  out  1  sticky flag: an accepted `sel` was ≥ N_IN.

## Operation
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- On accept, the selected word `in_data[sel]` is stored. If `sel` ≥ N_IN, the stored word is all zeros and `sel_err` is set.
- Storage holds two registers: main (drives `out_data`) and skid.
- The state machine is held in the package enum:
  - EMPTY: no entries.
  - ONE: main full.
  - TWO: main and skid full.
- Transitions:
  - EMPTY: accept → ONE, word loaded into main.
  - ONE:
    - accept and pop → ONE, main reloaded.
    - accept only → TWO, word loaded into skid.
    - pop only → EMPTY.
  - TWO: pop → ONE, skid moves to main. No accept is possible in TWO.
- `in_ready` = `reset_n & (state != TWO)`.
- `out_valid` = `state != EMPTY`.
- `out_data` = main. Main is zeroed when the state enters EMPTY.
- Flush:
  - Next state is EMPTY and both registers are zeroed.
  - Flush takes priority over a same-cycle accept; that word is dropped.
  - A same-cycle pop still counts as consumed downstream.
  - Flush does not clear `sel_err`.
- Order is strict FIFO: skid is always younger than main.
- A bad `sel` is only recorded on accept. A bad `sel` while `in_valid=0` or `in_ready=0` is ignored.

## Timing
- Reset values, sampled on the edge with `reset_n=0`:
  - state EMPTY.
  - `out_valid=0`, `out_data=0`, `sel_err=0`.
  - `in_ready=0` while `reset_n` is low, 1 on the first cycle after release.
- Reset mid-operation: all entries are lost and no pop is reported.
- Latency: a word accepted at edge t appears on `out_data` with `out_valid=1` in the cycle after edge t.
- There is no combinational input→output path.
- Throughput: 1 word/cycle while `out_ready=1`.
- Backpressure: with `out_ready=0` the block absorbs at most two words, then `in_ready` drops. `in_ready` returns in the cycle after the first pop.
- `out_data` is stable while `out_valid=1` and `out_ready=0`.

## Structure
- Package `mux_pkg` holds:
  - `typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t`.
  - `localparam int MAX_N_IN = 16`.
- Sub-module `mux_n`: purely combinational WIDTH×N_IN selector producing the word and an out-of-range flag. It is instantiated once, ahead of the registers.
- The top level holds the state register, main/skid registers and the `sel_err` flop.
- Elaboration assertion: 2 ≤ N_IN ≤ MAX_N_IN.

## Test plan
- Reset, then N_IN=4, WIDTH=64, inputs 0x11..,0x22..,0x33..,0x44.., `sel`=2, `in_valid`=1, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=0x3333…; no gaps while streaming `sel`=0,1,2,3.
- `out_ready`=0 while streaming 3 words → `in_ready` drops after 2 accepts. Raise `out_ready` → words emerge in order with no loss or duplicate.
- N_IN=5, accept with `sel`=6 → `out_data`=0 and `sel_err`=1. After reset, `sel_err`=0.
- State TWO with `flush`=1 and `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1; the offered word never appears.
- `reset_n`=0 held while in ONE → all outputs are zero next cycle. `in_ready`=0 during reset, 1 after release.
- Random `in_valid`/`out_ready` for 10k cycles against a scoreboard → FIFO order exact, and no change of `out_data` while `out_valid=1` and `out_ready=0`.
